// File: rtl/nn_fetch_stage.sv
// nn_fetch_stage: instruction fetch front end.
// Issues one request per cycle to a single-cycle-latency instruction memory.
// Fetched {pc, instr} pairs are buffered in a 2-entry FIFO feeding decode.
// Redirects flush both the FIFO and any response in flight.
// halt suppresses new requests but lets in-flight work drain.
// Optional feature macro: NN_FETCH_PERF_CNT_EN adds the fetch_count port and
// counts accepted instructions.
module nn_fetch_stage #(
  parameter int unsigned                 BUS_WIDTH  = 32,
  parameter int unsigned                 ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]       RESET_PC   = '0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [BUS_WIDTH-1:0]  imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BUS_WIDTH-1:0]  out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
`ifdef NN_FETCH_PERF_CNT_EN
  ,output logic [31:0]          fetch_count
`endif
);

  // Request stage (p0) state: next fetch address.
  logic [ADDR_WIDTH-1:0] pc;

  // Response stage (p1): a request issued last cycle whose data is on imem_rdata now.
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] pc_p1;

  // Output buffer: 2-entry FIFO of fetched pairs.
  logic [ADDR_WIDTH-1:0] fifo_pc    [2];
  logic [BUS_WIDTH-1:0]  fifo_instr [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            occ;

  logic                  pop;
  logic                  push;
  logic [2:0]            demand;

  assign pop    = out_valid & out_ready;
  // A response arriving in the redirect cycle belongs to the old path.
  assign push   = vld_p1 & ~redirect_valid;
  // Slots already committed after this cycle's pop; a new request needs one free.
  assign demand = {1'b0, occ} + {2'b0, vld_p1} - {2'b0, pop};

  assign imem_req  = RST_N & ~halt & ~redirect_valid & (demand < 3'd2);
  assign imem_addr = pc;

  assign out_valid = (occ != 2'd0);
  assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
  assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;

  // PC and in-flight flag: advance on issue, reload on redirect.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc     <= RESET_PC;
      vld_p1 <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (imem_req) begin
        pc <= pc + ADDR_WIDTH'(4);
      end
      vld_p1 <= imem_req;
    end
  end

  // Address of the outstanding request, paired with its data one cycle later.
  always_ff @(posedge CLK) begin
    if (imem_req) begin
      pc_p1 <= pc;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if (redirect_valid) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO storage written with the returning response.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= pc_p1;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

`ifdef NN_FETCH_PERF_CNT_EN
  // Accepted-instruction counter, including a pop coincident with a redirect.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_count <= 32'd0;
    end else if (pop) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`else
  // No performance counter in this build.
`endif

endmodule

// File: tb/tb_nn_fetch_stage.sv
// tb_nn_fetch_stage: scoreboard bench for nn_fetch_stage.
// Each issued request pushes its expected {pc, instr}; each handshake pops and compares.
// Build with NN_FETCH_PERF_CNT_EN defined to also cover fetch_count.
module tb_nn_fetch_stage;

  localparam int BW = 32;
  localparam int AW = 32;
  localparam logic [AW-1:0] RPC = '0;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [BW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_instr;
  logic [AW-1:0] out_pc;
`ifdef NN_FETCH_PERF_CNT_EN
  logic [31:0]   fetch_count;
`endif

  nn_fetch_stage #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef NN_FETCH_PERF_CNT_EN
    ,.fetch_count   (fetch_count)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [BW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Single-cycle instruction memory; junk when no request was made.
  always @(posedge CLK) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hBAD0_BAD0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [BW-1:0] instr;
  } ent_t;

  ent_t          sb[$];
  logic [AW-1:0] exp_pc;
  int            hs_cnt;
  int            n_checks;
  int            n_errors;
  logic          hold;
  ent_t          held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  task automatic monitor();
    ent_t e;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        sb.delete();
        exp_pc = RPC;
        hs_cnt = 0;
        hold   = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_pc", out_pc, held.pc);
          check("hold_instr", out_instr, held.instr);
        end
        if (out_valid && out_ready) begin
          hs_cnt++;
          check("pop_expected", sb.size() > 0, 1'b1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out_pc", out_pc, e.pc);
            check("out_instr", out_instr, e.instr);
          end
        end
        hold = out_valid && !out_ready && !redirect_valid;
        held = '{pc: out_pc, instr: out_instr};
        if (redirect_valid) begin
          check("redir_no_req", imem_req, 1'b0);
          sb.delete();
          exp_pc = redirect_pc;
        end else if (imem_req) begin
          check("req_addr", imem_addr, exp_pc);
          sb.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_addr(input logic [AW-1:0] target);
    for (int i = 0; i < 200; i++) begin
      if (imem_req && imem_addr == target) break;
      next();
      #1;
    end
    check("reach_addr", imem_addr, target);
  endtask

  task automatic do_reset(input logic ready_after);
    RST_N = 1'b0;
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_pc", out_pc, '0);
    check("rst_instr", out_instr, '0);
`ifdef NN_FETCH_PERF_CNT_EN
    check("rst_count", fetch_count, 32'd0);
`endif
    next();
    next();
    RST_N     = 1'b1;
    out_ready = ready_after;
  endtask

  initial begin
    RST_N          = 1'b0;
    out_ready      = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    n_checks       = 0;
    n_errors       = 0;
    hs_cnt         = 0;
    hold           = 1'b0;
    exp_pc         = RPC;
    fork
      monitor();
    join_none

    // Power-on reset, then stream with out_ready high.
    next();
    do_reset(1'b1);
    #1;
    check("c0_req", imem_req, 1'b1);
    check("c0_addr", imem_addr, RPC);
    check("c0_valid", out_valid, 1'b0);
    next(); #1;
    check("c1_valid", out_valid, 1'b0);
    check("c1_addr", imem_addr, 32'h4);
    next(); #1;
    check("c2_valid", out_valid, 1'b1);
    check("c2_pc", out_pc, 32'h0);
    next(); #1;
    check("c3_pc", out_pc, 32'h4);
    check("c3_addr", imem_addr, 32'hC);
    repeat (4) next();

    // Reset mid-stream with a request in flight, then back-pressure.
    do_reset(1'b0);
    repeat (3) next();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_req", imem_req, 1'b0);
      check("bp_valid", out_valid, 1'b1);
      check("bp_pc", out_pc, 32'h0);
      next();
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_pc", out_pc, 32'h0);
    check("bp_resume_req", imem_req, 1'b1);

    // Halt at 0x20 for 4 cycles.
    wait_addr(32'h20);
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("halt_req", imem_req, 1'b0);
      next();
    end
    #1;
    check("halt_drained", out_valid, 1'b0);
    halt = 1'b0;
    #1;
    check("halt_resume_req", imem_req, 1'b1);
    check("halt_resume_addr", imem_addr, 32'h20);

    // Redirect while streaming (coincident pop).
    wait_addr(32'h40);
    check("redir_pop", out_valid && out_ready, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    check("redir_req0", imem_req, 1'b0);
    next();
    redirect_valid = 1'b0;
    #1;
    check("redir_valid1", out_valid, 1'b0);
    check("redir_req1", imem_req, 1'b1);
    check("redir_addr1", imem_addr, 32'h100);
    next(); #1;
    check("redir_valid2", out_valid, 1'b0);
    next(); #1;
    check("redir_first_pc", out_pc, 32'h100);

    // Redirect with a full, stalled FIFO.
    out_ready = 1'b0;
    repeat (4) next();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    next();
    redirect_valid = 1'b0;
    #1;
    check("flush_valid", out_valid, 1'b0);
    check("flush_addr", imem_addr, 32'h200);
    out_ready = 1'b1;
    repeat (5) next();

    // Redirect during halt: PC updates, no request until halt drops.
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    next();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("hr_req", imem_req, 1'b0);
      next();
    end
    halt = 1'b0;
    #1;
    check("hr_req_on", imem_req, 1'b1);
    check("hr_addr", imem_addr, 32'h300);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF0;
    next();
    redirect_valid = 1'b0;
    wait_addr(32'hFFFF_FFFC);
    next(); #1;
    check("wrap_addr", imem_addr, 32'h0);
    repeat (4) next();

    // Random ready with occasional halt.
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      halt      = ($urandom_range(0, 7) == 0);
      next();
    end

    // Drain everything and confirm nothing was lost.
    halt      = 1'b1;
    out_ready = 1'b1;
    repeat (4) next();
    #1;
    check("drain_valid", out_valid, 1'b0);
    check("drain_sb", sb.size(), 0);
`ifdef NN_FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, hs_cnt);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nn_fetch_stage.md
NN_FETCH_STAGE -- requirements
Module: nn_fetch_stage

Interface
REQ-001 Parameter: BUS_WIDTH, 32, instruction/data width in bits.
REQ-002 Parameter: ADDR_WIDTH, 32, byte-address width of the PC.
REQ-003 Parameter: RESET_PC, 0, first fetch address after reset.
REQ-004 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-005 Port: RST_N  input  1  asynchronous, active-low reset.
REQ-006 Port: imem_req  output  1  fetch request to instruction memory this cycle.
REQ-007 Port: imem_addr  output  ADDR_WIDTH  fetch address, valid when imem_req=1.
REQ-008 Port: imem_rdata  input  BUS_WIDTH  instruction word, valid exactly one cycle after its imem_req.
REQ-009 Port: redirect_valid  input  1  branch/jump redirect from downstream stage.
REQ-010 Port: redirect_pc  input  ADDR_WIDTH  redirect target.
REQ-011 Port: halt  input  1  stop issuing new fetches.
REQ-012 Port: out_valid  output  1  instruction available to decode stage.
REQ-013 Port: out_ready  input  1  decode stage accepts; transfer when out_valid & out_ready.
REQ-014 Port: out_instr  output  BUS_WIDTH  fetched instruction.
REQ-015 Port: out_pc  output  ADDR_WIDTH  address of out_instr.
REQ-016 Port: fetch_count  output  32  accepted-instruction count (present only per REQ-033).

Function
REQ-017 SHALL hold fetched {pc, instr} pairs in a 2-entry FIFO; out_* SHALL show the head entry, out_valid = FIFO non-empty.
REQ-018 SHALL assert imem_req combinationally when !halt & !redirect_valid & (occupancy + inflight - pop) < 2, where pop = out_valid & out_ready.
REQ-019 imem_addr SHALL equal the PC register; PC SHALL advance by 4 on each issued request, wrapping modulo 2^ADDR_WIDTH.
REQ-020 A response SHALL be written into the FIFO at the end of the cycle after its request; latency request -> out_valid = 2 cycles.
REQ-021 Simultaneous FIFO write and pop SHALL leave occupancy unchanged and preserve order; no entry SHALL be dropped or duplicated.
REQ-022 With out_ready held high and no redirect/halt, SHALL sustain one instruction per cycle after the initial 2-cycle latency.
REQ-023 out_instr/out_pc SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 On redirect_valid: FIFO SHALL be flushed, any in-flight response discarded, PC loaded with redirect_pc, imem_req=0 that cycle; first request to redirect_pc issued the next cycle.
REQ-025 Redirect coincident with pop: the pop SHALL count as accepted; redirect still flushes the remainder.
REQ-026 redirect_pc SHALL be used as given (no alignment check).
REQ-027 halt=1 SHALL suppress new requests only; in-flight response still enters FIFO and FIFO drains normally; fetching resumes at the held PC when halt=0.
REQ-028 Redirect during halt SHALL update PC and flush; no request issues until halt=0.

Reset
REQ-029 RST_N=0 SHALL asynchronously clear FIFO, inflight flag and counters; PC = RESET_PC.
REQ-030 During reset: imem_req=0, out_valid=0, out_instr=0, out_pc=0, fetch_count=0.
REQ-031 A response arriving in the first cycle after reset release SHALL be discarded.
REQ-032 First request (addr RESET_PC) SHALL issue in the first cycle with RST_N=1 and halt=0.

Configuration
REQ-033 Macro NN_FETCH_PERF_CNT_EN: when defined, fetch_count port exists and increments by 1 on each out_valid & out_ready (wraps at 2^32); when undefined, port and counter SHALL be absent and behaviour otherwise identical.

Verification
REQ-034 Reset release, RESET_PC=0, out_ready=1, memory returns addr-derived words -> imem_addr 0,4,8,... one per cycle; out_valid first high 2 cycles after first request; out_pc 0,4,8 in order.
REQ-035 out_ready=0 for 5 cycles after first fetch -> occupancy reaches 2, imem_req drops, out_pc holds 0x0; on out_ready=1 stream resumes 0x0,0x4,0x8 with no gaps or duplicates.
REQ-036 redirect_valid pulse with redirect_pc=0x100 while 2 entries buffered and 1 in flight -> next cycle out_valid=0, imem_addr=0x100; first delivered out_pc=0x100.
REQ-037 halt=1 at PC=0x20 for 4 cycles -> no imem_req, buffered entries drain, out_valid=0; halt=0 -> request at 0x20.
REQ-038 RST_N pulsed low mid-stream with a request in flight -> outputs zero immediately, stale rdata not delivered, restart at RESET_PC.
REQ-039 With NN_FETCH_PERF_CNT_EN, 10 handshakes including one during redirect -> fetch_count=10; PC at 0xFFFFFFFC wraps to 0x0.
